// File: rtl/beta_mem_seq.sv
// Beta MEM-stage sequencer: runs the data-memory req/ack handshake for LD/LDR/ST and stalls the pipe meanwhile.
// Optional watchdog abort on a missing ack is enabled by defining BETA_MEM_TIMEOUT_EN.
module beta_mem_seq #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic              mem_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ma,
    input  logic [DATA_W-1:0] mwd,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [5:0] OP_ST  = 6'b011001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_squash;
    logic              r_mem_err;
    logic              w_is_mem;
    logic              w_start;
    logic              w_expire;

`ifdef BETA_MEM_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    // Expiry is flagged in the last permitted WAIT cycle so WAIT lasts exactly TIMEOUT_CYCLES cycles.
    assign w_expire = (r_state == S_WAIT) && !mem_ack && (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    assign w_is_mem = (opcode == OP_LD) || (opcode == OP_LDR) || (opcode == OP_ST);
    assign w_start  = !rst && mem_valid && w_is_mem && !flush && (r_state == S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_WAIT;
            S_WAIT:  if (mem_ack || w_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_data   <= '0;
            r_squash    <= 1'b0;
            r_mem_err   <= 1'b0;
`ifdef BETA_MEM_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
`endif
        end else begin
            r_state   <= w_next;
            r_mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_addr  <= ma;
                        r_mem_wdata <= mwd;
                        r_mem_we    <= (opcode == OP_ST);
                        r_mem_req   <= 1'b1;
`ifdef BETA_MEM_TIMEOUT_EN
                        r_tmo_cnt   <= 8'd0;
`endif
                    end
                end
                S_WAIT: begin
                    if (flush) r_squash <= 1'b1;
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) r_ld_data <= mem_rdata;
                    end else if (w_expire) begin
                        r_mem_req <= 1'b0;
                        r_ld_data <= '0;
                        r_mem_err <= 1'b1;
                    end
`ifdef BETA_MEM_TIMEOUT_EN
                    if (!mem_ack) r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
                end
                S_DONE:  r_squash <= 1'b0;
                default: r_squash <= 1'b0;
            endcase
        end
    end

    assign stall     = !rst && (w_start || (r_state == S_WAIT));
    assign ld_valid  = (r_state == S_DONE) && !r_mem_we && !r_squash && !r_mem_err;
    assign ld_data   = r_ld_data;
    assign mem_err   = r_mem_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_beta_mem_seq.sv
// Directed bench for beta_mem_seq: inputs driven 1 ns after the rising edge, outputs checked on the falling edge.
module tb_beta_mem_seq;

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_valid;
    logic        flush;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        mem_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    beta_mem_seq #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .opcode(opcode),
        .mem_valid(mem_valid),
        .flush(flush),
        .ma(ma),
        .mwd(mwd),
        .stall(stall),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .mem_err(mem_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode = OP_LD; mem_valid = 1'b1; flush = 1'b0;
        ma = '0; mwd = '0; mem_ack = 1'b0; mem_rdata = '0;

        // reset: stall must stay low even with a valid LD present
        sample(); chk("rst_stall0", 32'(stall), 32'd0);
        step();
        sample();
        chk("rst_stall1", 32'(stall),   32'd0);
        chk("rst_req",    32'(mem_req), 32'd0);
        chk("rst_we",     32'(mem_we),  32'd0);
        chk("rst_addr",   mem_addr,     32'd0);
        chk("rst_wdata",  mem_wdata,    32'd0);
        chk("rst_lddata", ld_data,      32'd0);
        chk("rst_ldval",  32'(ld_valid),32'd0);
        chk("rst_err",    32'(mem_err), 32'd0);
        rst = 1'b0; mem_valid = 1'b0;
        step();

        // non-memory op: fully transparent
        opcode = OP_ADD; mem_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("add_stall_req", {30'd0, stall, mem_req}, 32'd0);
            step();
        end

        // LD 0x100, ack in second WAIT cycle
        opcode = OP_LD; ma = 32'h100;
        sample(); chk("ld_det_stall", 32'(stall), 32'd1); chk("ld_det_req", 32'(mem_req), 32'd0);
        step();
        sample();
        chk("ld_w1_stall", 32'(stall),   32'd1);
        chk("ld_w1_req",   32'(mem_req), 32'd1);
        chk("ld_w1_we",    32'(mem_we),  32'd0);
        chk("ld_w1_addr",  mem_addr,     32'h100);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        sample(); chk("ld_w2_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        sample();
        chk("ld_done_stall", 32'(stall),    32'd0);
        chk("ld_done_valid", 32'(ld_valid), 32'd1);
        chk("ld_done_data",  ld_data,       32'hDEADBEEF);
        chk("ld_done_req",   32'(mem_req),  32'd0);
        step();

        // stray ack while idle is ignored
        opcode = OP_ADD; mem_ack = 1'b1; mem_rdata = 32'h1111;
        sample(); chk("stray_stall", 32'(stall), 32'd0);
        step();
        mem_ack = 1'b0;
        sample();
        chk("stray_data",  ld_data,       32'hDEADBEEF);
        chk("stray_req",   32'(mem_req),  32'd0);
        chk("stray_valid", 32'(ld_valid), 32'd0);
        step();

        // LD squashed by flush during WAIT
        opcode = OP_LD; ma = 32'h200;
        sample(); chk("sq_det_stall", 32'(stall), 32'd1);
        step();
        flush = 1'b1;
        sample(); chk("sq_w1_stall", 32'(stall), 32'd1); chk("sq_w1_req", 32'(mem_req), 32'd1);
        step();
        flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000CAFE;
        sample(); chk("sq_w2_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b0; opcode = OP_ST; ma = 32'h40; mwd = 32'h12345678;
        sample();
        chk("sq_done_valid", 32'(ld_valid), 32'd0);
        chk("sq_done_data",  ld_data,       32'h0000CAFE);
        chk("sq_done_stall", 32'(stall),    32'd0);
        step();

        // ST then LD back-to-back, each acked in its first WAIT cycle
        sample(); chk("st_det_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        sample();
        chk("st_w1_req",   32'(mem_req), 32'd1);
        chk("st_w1_we",    32'(mem_we),  32'd1);
        chk("st_w1_addr",  mem_addr,     32'h40);
        chk("st_w1_wdata", mem_wdata,    32'h12345678);
        step();
        mem_ack = 1'b0;
        sample();
        chk("st_done_stall", 32'(stall),    32'd0);
        chk("st_done_valid", 32'(ld_valid), 32'd0);
        chk("st_done_data",  ld_data,       32'h0000CAFE);
        step();
        opcode = OP_LD; ma = 32'h80;
        sample(); chk("b2b_det_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h000055AA;
        sample();
        chk("b2b_w1_we",   32'(mem_we), 32'd0);
        chk("b2b_w1_addr", mem_addr,    32'h80);
        step();
        mem_ack = 1'b0;
        sample();
        chk("b2b_done_valid", 32'(ld_valid), 32'd1);
        chk("b2b_done_data",  ld_data,       32'h000055AA);
        step();

        // no ack: watchdog abort when enabled, indefinite wait otherwise
        ma = 32'h300;
        sample(); chk("to_det_stall", 32'(stall), 32'd1);
        step();
`ifdef BETA_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("to_wait_req", 32'(mem_req), 32'd1);
            chk("to_wait_err", 32'(mem_err), 32'd0);
            step();
        end
        sample();
        chk("to_done_req",   32'(mem_req),  32'd0);
        chk("to_done_err",   32'(mem_err),  32'd1);
        chk("to_done_data",  ld_data,       32'd0);
        chk("to_done_valid", 32'(ld_valid), 32'd0);
        chk("to_done_stall", 32'(stall),    32'd0);
        step();
        opcode = OP_ADD;
        sample(); chk("to_err_pulse", 32'(mem_err), 32'd0); chk("to_resume_stall", 32'(stall), 32'd0);
        step();
`else
        for (int i = 0; i < 12; i++) begin
            sample();
            chk("nt_wait_stall", 32'(stall),   32'd1);
            chk("nt_wait_req",   32'(mem_req), 32'd1);
            chk("nt_wait_err",   32'(mem_err), 32'd0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000ABCD;
        sample(); chk("nt_ack_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b0; opcode = OP_ADD;
        sample();
        chk("nt_done_valid", 32'(ld_valid), 32'd1);
        chk("nt_done_data",  ld_data,       32'h0000ABCD);
        chk("nt_done_err",   32'(mem_err),  32'd0);
        step();
`endif

        // reset in the middle of WAIT, late ack afterwards
        opcode = OP_LD; ma = 32'h400;
        sample(); chk("rw_det_stall", 32'(stall), 32'd1);
        step();
        sample(); chk("rw_w1_req", 32'(mem_req), 32'd1);
        step();
        rst = 1'b1; mem_valid = 1'b0;
        sample(); chk("rw_rst_stall", 32'(stall), 32'd0);
        step();
        rst = 1'b0;
        sample(); chk("rw_after_req", 32'(mem_req), 32'd0); chk("rw_after_stall", 32'(stall), 32'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h00009999;
        sample(); chk("rw_late_stall", 32'(stall), 32'd0);
        step();
        mem_ack = 1'b0;
        sample();
        chk("rw_late_req",   32'(mem_req),  32'd0);
        chk("rw_late_data",  ld_data,       32'd0);
        chk("rw_late_valid", 32'(ld_valid), 32'd0);
        step();
        mem_valid = 1'b1;
        sample(); chk("rw_idle_det", 32'(stall), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
